// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - configurable UART frame transmitter with input word FIFO
// Start/data/parity/stop serialiser; config is latched per frame at the FIFO pop.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_WIDTH-1:0]     PRESCALE,
  output logic                          TX_OUT,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  state_t                state_q,     state_d;
  logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]      count_q,     count_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  par_en_q,    par_en_d;
  logic                  par_typ_q,   par_typ_d;
  logic                  stop2_q,     stop2_d;
  logic [4:0]            pmax_q,      pmax_d;
  logic [4:0]            presc_cnt_q, presc_cnt_d;
  logic [IDX_W-1:0]      bit_idx_q,   bit_idx_d;
  logic                  stop_half_q, stop_half_d;
  logic                  tx_out_q,    tx_out_d;
  logic                  busy_q,      busy_d;

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_nonempty;

  // Bit period minus one; anything other than 4/8/16 runs at 32.
  function automatic logic [4:0] decode_pmax(input logic [PRESCALE_WIDTH-1:0] p);
    logic [4:0] r;
    case (32'(p))
      4:       r = 5'd3;
      8:       r = 5'd7;
      16:      r = 5'd15;
      default: r = 5'd31;
    endcase
    return r;
  endfunction

  assign TX_READY      = !RST && (count_q < CNT_W'(FIFO_DEPTH));
  assign push          = TX_VALID && TX_READY;
  assign fifo_nonempty = (count_q != '0);
  assign bit_end       = (presc_cnt_q == pmax_q);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    stop2_d     = stop2_q;
    pmax_d      = pmax_q;
    presc_cnt_d = presc_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_half_d = stop_half_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop         = 1'b1;
          state_d     = S_START;
          presc_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d     = S_DATA;
          presc_cnt_d = '0;
          bit_idx_d   = '0;
        end else begin
          presc_cnt_d = presc_cnt_q + 5'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          presc_cnt_d = '0;
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d     = par_en_q ? S_PARITY : S_STOP;
            stop_half_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          presc_cnt_d = presc_cnt_q + 5'd1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d     = S_STOP;
          presc_cnt_d = '0;
          stop_half_d = 1'b0;
        end else begin
          presc_cnt_d = presc_cnt_q + 5'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          presc_cnt_d = '0;
          if (stop2_q && !stop_half_q) begin
            stop_half_d = 1'b1;
          end else if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          presc_cnt_d = presc_cnt_q + 5'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        presc_cnt_d = '0;
      end
    endcase

    if (pop) begin
      data_d    = fifo_mem[rd_ptr_q];
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
      pmax_d    = decode_pmax(PRESCALE);
    end
  end

  // Line and BUSY follow the current state one cycle later so TX_OUT is glitch-free.
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = data_q[bit_idx_q];
      S_PARITY: tx_out_d = par_typ_q ? ~^data_q : ^data_q;
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= TX_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      pmax_q      <= 5'd31;
      presc_cnt_q <= '0;
      bit_idx_q   <= '0;
      stop_half_q <= 1'b0;
      tx_out_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      stop2_q     <= stop2_d;
      pmax_q      <= pmax_d;
      presc_cnt_q <= presc_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_half_q <= stop_half_d;
      tx_out_q    <= tx_out_d;
      busy_q      <= busy_d;
    end
  end

  assign TX_OUT     = tx_out_q;
  assign BUSY       = busy_q;
  assign FIFO_COUNT = count_q;

endmodule
